// File: rtl/sddr_pkg.sv
// sddr_pkg: shared types and constants for the DDR3 write-leveling sequencer.
//   cmd_e        command kinds driven on the PHY command bus
//   state_e      sequencer states
//   cmd_pins_t   cs_n/ras_n/cas_n/we_n pin bundle
//   encode_cmd   command kind -> pin levels
//   wait_load    timer load value for a wait that lasts a given number of cycles
package sddr_pkg;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_MRS,
        CMD_DESELECT
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MRS_ON,
        ST_WAIT_MOD_ON,
        ST_ODT_ON,
        ST_WAIT_DQSEN,
        ST_PULSE,
        ST_WAIT_WLO,
        ST_EVAL,
        ST_INC,
        ST_SETTLE,
        ST_MRS_OFF,
        ST_WAIT_MOD_OFF
    } state_e;

    // MR1 bit that enables write-leveling mode, and the bank that selects MR1
    localparam int MR1_WL_BIT = 7;
    localparam int MR1_BANK   = 1;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } cmd_pins_t;

    function automatic cmd_pins_t encode_cmd(cmd_e cmd);
        cmd_pins_t pins;
        case (cmd)
            CMD_NOP: pins = 4'b0111;
            CMD_MRS: pins = 4'b0000;
            default: pins = 4'b1111;
        endcase
        return pins;
    endfunction

    // The timer is loaded on state entry and the state leaves when it reads
    // zero, so a load of N keeps the state for N+1 cycles.
    function automatic int unsigned wait_load(int unsigned cycles);
        return (cycles > 1) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/sddr_write_level_seq_if.sv
// sddr_write_level_seq_if: control/status and PHY command bundle of the
// write-leveling sequencer.
//   master : the sequencer (drives status and PHY command/delay signals)
//   slave  : the surrounding init logic and PHY
interface sddr_write_level_seq_if #(
    parameter int BANK_BITS = 3,
    parameter int ADDR_BITS = 14,
    parameter int LANES     = 2,
    parameter int TAP_BITS  = 6
);
    logic                      start_i;
    logic [ADDR_BITS-1:0]      mr1_value_i;
    logic [LANES-1:0]          wl_feedback_i;
    logic                      busy_o;
    logic                      done_o;
    logic                      error_o;
    logic [LANES*TAP_BITS-1:0] tap_count_o;
    logic                      ctl_cs_n_o;
    logic                      ctl_ras_n_o;
    logic                      ctl_cas_n_o;
    logic                      ctl_we_n_o;
    logic [BANK_BITS-1:0]      ctl_ba_o;
    logic [ADDR_BITS-1:0]      ctl_addr_o;
    logic                      ctl_odt_o;
    logic                      ctl_write_level_o;
    logic                      ctl_out_dqs_o;
    logic [LANES-1:0]          ctl_delay_inc_o;

    modport master (
        input  start_i, mr1_value_i, wl_feedback_i,
        output busy_o, done_o, error_o, tap_count_o,
               ctl_cs_n_o, ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o,
               ctl_ba_o, ctl_addr_o, ctl_odt_o, ctl_write_level_o,
               ctl_out_dqs_o, ctl_delay_inc_o
    );

    modport slave (
        output start_i, mr1_value_i, wl_feedback_i,
        input  busy_o, done_o, error_o, tap_count_o,
               ctl_cs_n_o, ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o,
               ctl_ba_o, ctl_addr_o, ctl_odt_o, ctl_write_level_o,
               ctl_out_dqs_o, ctl_delay_inc_o
    );
endinterface

// File: rtl/sddr_wait_timer.sv
// sddr_wait_timer: loadable down-counter that stops at zero.
//   clk, rst    clock and synchronous active-high reset
//   load        load load_value this cycle (takes priority over counting)
//   load_value  new count
//   zero        count has reached zero
module sddr_wait_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    // Count down to zero and hold there until the next load
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/sddr_write_level_seq.sv
// sddr_write_level_seq: DDR3 write-leveling sequencer.
// Enters MR1 write-level mode, enables ODT, pulses DQS and steps each byte
// lane's DQS delay until its feedback shows a 0->1 transition, then leaves
// write-level mode and reports done or error. All PHY outputs are registered.
//   in_ddr_clock_i  controller clock
//   in_reset_i      synchronous active-high reset
//   bus             control/status and PHY command/delay signals (master side)
module sddr_write_level_seq
    import sddr_pkg::*;
#(
    parameter int BANK_BITS = 3,
    parameter int ADDR_BITS = 14,
    parameter int LANES     = 2,
    parameter int T_MOD     = 12,
    parameter int T_WLDQSEN = 25,
    parameter int T_WLO     = 8,
    parameter int T_SETTLE  = 4,
    parameter int MAX_TAPS  = 32
) (
    input  logic                   in_ddr_clock_i,
    input  logic                   in_reset_i,
    sddr_write_level_seq_if.master bus
);
    localparam int TAP_BITS   = $clog2(MAX_TAPS + 1);
    localparam int T_MAX_A    = (T_MOD > T_WLDQSEN) ? T_MOD : T_WLDQSEN;
    localparam int T_MAX_B    = (T_WLO > T_SETTLE) ? T_WLO : T_SETTLE;
    localparam int T_MAX      = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int TIMER_BITS = $clog2(T_MAX + 1);

    state_e                state, state_next;
    logic [ADDR_BITS-1:0]  mr1_q, mr1_d;
    logic [LANES-1:0]      found_q, found_d, seen_q, seen_d, req_q, req_d;
    logic [TAP_BITS-1:0]   taps_q [LANES];
    logic [TAP_BITS-1:0]   taps_d [LANES];
    logic                  fail_q, fail_d, at_limit;
    logic                  timer_zero;
    logic [TIMER_BITS-1:0] timer_value;
    logic [ADDR_BITS-1:0]  mrs_addr;

    cmd_pins_t             cmd_q, cmd_d;
    logic [BANK_BITS-1:0]  ba_q, ba_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  odt_q, odt_d, dqs_q, dqs_d;
    logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [LANES-1:0]      inc_q, inc_d;
    logic [LANES*TAP_BITS-1:0] tap_flat;

    // The wait timer is reloaded whenever the state changes
    sddr_wait_timer #(.WIDTH(TIMER_BITS)) u_timer (
        .clk        (in_ddr_clock_i),
        .rst        (in_reset_i),
        .load       (state_next != state),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Load value for the state about to be entered. The DQSEN wait is one
    // cycle short so that the registered DQS pulse lands exactly T_WLDQSEN
    // cycles after the registered ODT rise.
    always_comb begin
        timer_value = '0;
        case (state_next)
            ST_WAIT_MOD_ON, ST_WAIT_MOD_OFF: timer_value = TIMER_BITS'(wait_load(T_MOD));
            ST_WAIT_DQSEN:                   timer_value = TIMER_BITS'(wait_load(T_WLDQSEN - 1));
            ST_WAIT_WLO:                     timer_value = TIMER_BITS'(wait_load(T_WLO));
            ST_SETTLE:                       timer_value = TIMER_BITS'(wait_load(T_SETTLE));
            default:                         timer_value = '0;
        endcase
    end

    // Next state plus per-lane leveling bookkeeping. A lane only locks on a
    // 1 that follows a 0 it has already seen, so a lane that starts out
    // reading 1 keeps stepping instead of locking at tap 0.
    always_comb begin
        state_next = state;
        mr1_d      = mr1_q;
        found_d    = found_q;
        seen_d     = seen_q;
        req_d      = req_q;
        taps_d     = taps_q;
        fail_d     = fail_q;
        at_limit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_next = ST_MRS_ON;
                    mr1_d      = bus.mr1_value_i;
                    found_d    = '0;
                    seen_d     = '0;
                    req_d      = '0;
                    fail_d     = 1'b0;
                    for (int l = 0; l < LANES; l++) taps_d[l] = '0;
                end
            end
            ST_MRS_ON:      state_next = ST_WAIT_MOD_ON;
            ST_WAIT_MOD_ON: if (timer_zero) state_next = ST_ODT_ON;
            ST_ODT_ON:      state_next = ST_WAIT_DQSEN;
            ST_WAIT_DQSEN:  if (timer_zero) state_next = ST_PULSE;
            ST_PULSE:       state_next = ST_WAIT_WLO;
            ST_WAIT_WLO:    if (timer_zero) state_next = ST_EVAL;
            ST_EVAL: begin
                for (int l = 0; l < LANES; l++) begin
                    req_d[l] = 1'b0;
                    if (!found_q[l]) begin
                        if (!bus.wl_feedback_i[l]) begin
                            seen_d[l] = 1'b1;
                            req_d[l]  = 1'b1;
                        end else if (seen_q[l]) begin
                            found_d[l] = 1'b1;
                        end else begin
                            req_d[l] = 1'b1;
                        end
                        if (req_d[l] && taps_q[l] == TAP_BITS'(MAX_TAPS - 1)) at_limit = 1'b1;
                    end
                end
                if (&found_d) begin
                    state_next = ST_MRS_OFF;
                end else if (at_limit) begin
                    fail_d     = 1'b1;
                    state_next = ST_MRS_OFF;
                end else begin
                    state_next = ST_INC;
                end
            end
            ST_INC: begin
                for (int l = 0; l < LANES; l++) begin
                    if (req_q[l]) taps_d[l] = taps_q[l] + 1'b1;
                end
                state_next = ST_SETTLE;
            end
            ST_SETTLE:       if (timer_zero) state_next = ST_PULSE;
            ST_MRS_OFF:      state_next = ST_WAIT_MOD_OFF;
            ST_WAIT_MOD_OFF: if (timer_zero) state_next = ST_IDLE;
            default:         state_next = ST_IDLE;
        endcase
    end

    // Values for the registered PHY/status outputs, derived from the current
    // state so each command occupies exactly one cycle on the bus.
    always_comb begin
        mrs_addr = mr1_q;
        mrs_addr[MR1_WL_BIT] = (state == ST_MRS_ON);
        cmd_d   = encode_cmd(CMD_NOP);
        ba_d    = '0;
        addr_d  = '0;
        case (state)
            ST_IDLE: cmd_d = encode_cmd(CMD_DESELECT);
            ST_MRS_ON, ST_MRS_OFF: begin
                cmd_d  = encode_cmd(CMD_MRS);
                ba_d   = BANK_BITS'(MR1_BANK);
                addr_d = mrs_addr;
            end
            default: cmd_d = encode_cmd(CMD_NOP);
        endcase
        odt_d   = (state inside {ST_ODT_ON, ST_WAIT_DQSEN, ST_PULSE, ST_WAIT_WLO,
                                 ST_EVAL, ST_INC, ST_SETTLE});
        dqs_d   = (state == ST_PULSE);
        inc_d   = (state == ST_INC) ? req_q : '0;
        busy_d  = (state_next != ST_IDLE);
        done_d  = (state == ST_WAIT_MOD_OFF) && timer_zero && !fail_q;
        error_d = (state == ST_WAIT_MOD_OFF) && timer_zero && fail_q;
    end

    // State, bookkeeping and output registers; reset releases the bus at once
    always_ff @(posedge in_ddr_clock_i) begin
        if (in_reset_i) begin
            state   <= ST_IDLE;
            mr1_q   <= '0;
            found_q <= '0;
            seen_q  <= '0;
            req_q   <= '0;
            fail_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) taps_q[l] <= '0;
            cmd_q   <= encode_cmd(CMD_DESELECT);
            ba_q    <= '0;
            addr_q  <= '0;
            odt_q   <= 1'b0;
            dqs_q   <= 1'b0;
            inc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_next;
            mr1_q   <= mr1_d;
            found_q <= found_d;
            seen_q  <= seen_d;
            req_q   <= req_d;
            fail_q  <= fail_d;
            taps_q  <= taps_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            odt_q   <= odt_d;
            dqs_q   <= dqs_d;
            inc_q   <= inc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Pack the per-lane tap counters, lane 0 in the low bits
    always_comb begin
        tap_flat = '0;
        for (int l = 0; l < LANES; l++) tap_flat[l*TAP_BITS +: TAP_BITS] = taps_q[l];
    end

    assign bus.ctl_cs_n_o        = cmd_q.cs_n;
    assign bus.ctl_ras_n_o       = cmd_q.ras_n;
    assign bus.ctl_cas_n_o       = cmd_q.cas_n;
    assign bus.ctl_we_n_o        = cmd_q.we_n;
    assign bus.ctl_ba_o          = ba_q;
    assign bus.ctl_addr_o        = addr_q;
    assign bus.ctl_odt_o         = odt_q;
    assign bus.ctl_write_level_o = odt_q;
    assign bus.ctl_out_dqs_o     = dqs_q;
    assign bus.ctl_delay_inc_o   = inc_q;
    assign bus.busy_o            = busy_q;
    assign bus.done_o            = done_q;
    assign bus.error_o           = error_q;
    assign bus.tap_count_o       = tap_flat;
endmodule

// File: tb/tb_sddr_write_level_seq.sv
// tb_sddr_write_level_seq: self-checking bench for sddr_write_level_seq.
// A PHY model returns per-lane feedback from a bit pattern indexed by the
// lane's current delay tap (advanced on every delay_inc seen). Expected
// results are derived directly from the patterns.
module tb_sddr_write_level_seq;
    localparam int BANK_BITS = 3;
    localparam int ADDR_BITS = 14;
    localparam int LANES     = 2;
    localparam int T_MOD     = 12;
    localparam int T_WLDQSEN = 25;
    localparam int T_WLO     = 8;
    localparam int T_SETTLE  = 4;
    localparam int MAX_TAPS  = 32;
    localparam int TAP_BITS  = 6;
    localparam int BUDGET    = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int check_count = 0;
    int fail_count  = 0;

    // PHY model and monitor state
    logic [31:0] pat [LANES];
    int model_tap [LANES];
    int inc_cnt   [LANES];
    int cyc = 0;
    int mrs_cnt, mrs_cyc, odt_cyc, dqs_cyc, dqs_cnt, done_cnt, err_cnt;
    logic [ADDR_BITS-1:0] first_addr, last_addr;
    logic [BANK_BITS-1:0] first_ba;
    logic odt_prev = 1'b0;

    sddr_write_level_seq_if #(
        .BANK_BITS(BANK_BITS), .ADDR_BITS(ADDR_BITS), .LANES(LANES), .TAP_BITS(TAP_BITS)
    ) bus ();

    sddr_write_level_seq #(
        .BANK_BITS(BANK_BITS), .ADDR_BITS(ADDR_BITS), .LANES(LANES),
        .T_MOD(T_MOD), .T_WLDQSEN(T_WLDQSEN), .T_WLO(T_WLO),
        .T_SETTLE(T_SETTLE), .MAX_TAPS(MAX_TAPS)
    ) dut (
        .in_ddr_clock_i (clk),
        .in_reset_i     (rst),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clearMonitor();
        for (int l = 0; l < LANES; l++) begin
            model_tap[l] = 0;
            inc_cnt[l]   = 0;
        end
        mrs_cnt = 0; mrs_cyc = -1; odt_cyc = -1; dqs_cyc = -1; dqs_cnt = 0;
        done_cnt = 0; err_cnt = 0;
        first_addr = '0; last_addr = '0; first_ba = '0;
    endtask

    // PHY model and bus monitor, sampled away from the active edge
    always @(negedge clk) begin
        logic [LANES-1:0] fb;
        cyc++;
        for (int l = 0; l < LANES; l++) begin
            if (bus.ctl_delay_inc_o[l]) begin
                inc_cnt[l]++;
                if (model_tap[l] < MAX_TAPS - 1) model_tap[l]++;
            end
            fb[l] = pat[l][model_tap[l]];
        end
        bus.wl_feedback_i = fb;
        if (!bus.ctl_cs_n_o && !bus.ctl_ras_n_o && !bus.ctl_cas_n_o && !bus.ctl_we_n_o) begin
            mrs_cnt++;
            if (mrs_cnt == 1) begin
                first_addr = bus.ctl_addr_o;
                first_ba   = bus.ctl_ba_o;
                mrs_cyc    = cyc;
            end
            last_addr = bus.ctl_addr_o;
        end
        if (bus.ctl_odt_o && !odt_prev && odt_cyc < 0) odt_cyc = cyc;
        odt_prev = bus.ctl_odt_o;
        if (bus.ctl_out_dqs_o) begin
            if (dqs_cnt == 0) dqs_cyc = cyc;
            dqs_cnt++;
        end
        if (bus.done_o)  done_cnt++;
        if (bus.error_o) err_cnt++;
    end

    // Run one full leveling sequence and check it against the patterns
    task automatic applyStimulus(input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [ADDR_BITS-1:0] mr1, input bit hold);
        int   exp_tap [LANES];
        bit   exp_err;
        bit   seen, found;
        int   waited;
        int   iters;
        logic [ADDR_BITS-1:0] on_addr, off_addr;
        pat[0] = p0;
        pat[1] = p1;
        clearMonitor();
        bus.mr1_value_i = mr1;
        bus.start_i     = 1'b1;
        @(negedge clk);
        if (!hold) bus.start_i = 1'b0;
        waited = 0;
        while (!(bus.done_o || bus.error_o) && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        bus.start_i = 1'b0;
        checkOutput("finish_in_budget", 32'(waited < BUDGET), 1);
        repeat (6) @(negedge clk);

        // A lane locks at the first tap reading 1 after some earlier tap read 0
        exp_err = 1'b0;
        iters   = 0;
        for (int l = 0; l < LANES; l++) begin
            seen  = 1'b0;
            found = 1'b0;
            exp_tap[l] = MAX_TAPS - 1;
            for (int t = 0; t < MAX_TAPS; t++) begin
                if (!found) begin
                    if (!pat[l][t]) seen = 1'b1;
                    else if (seen) begin
                        found = 1'b1;
                        exp_tap[l] = t;
                    end
                end
            end
            if (!found) exp_err = 1'b1;
            if (exp_tap[l] > iters) iters = exp_tap[l];
        end
        on_addr  = mr1 | ADDR_BITS'(16'h0080);
        off_addr = mr1 & ~ADDR_BITS'(16'h0080);

        checkOutput("done_pulses",  done_cnt, 32'(!exp_err));
        checkOutput("error_pulses", err_cnt,  32'(exp_err));
        checkOutput("tap_count",    bus.tap_count_o, 32'({exp_tap[1][5:0], exp_tap[0][5:0]}));
        checkOutput("lane0_incs",   inc_cnt[0], exp_tap[0]);
        checkOutput("lane1_incs",   inc_cnt[1], exp_tap[1]);
        checkOutput("dqs_pulses",   dqs_cnt, iters + 1);
        checkOutput("mrs_count",    mrs_cnt, 2);
        checkOutput("mrs_on_addr",  first_addr, 32'(on_addr));
        checkOutput("mrs_on_bank",  first_ba, 1);
        checkOutput("mrs_off_addr", last_addr, 32'(off_addr));
        checkOutput("mrs_to_odt",   odt_cyc - mrs_cyc, T_MOD + 1);
        checkOutput("odt_to_dqs",   dqs_cyc - odt_cyc, T_WLDQSEN);
        checkOutput("idle_busy",    bus.busy_o, 0);
        checkOutput("idle_odt",     bus.ctl_odt_o, 0);
        checkOutput("idle_wl",      bus.ctl_write_level_o, 0);
        checkOutput("idle_cs_n",    bus.ctl_cs_n_o, 1);
    endtask

    initial begin
        int waited;
        int k;
        logic [31:0] p0, p1;
        pat[0] = '1;
        pat[1] = '1;
        clearMonitor();
        bus.start_i       = 1'b0;
        bus.mr1_value_i   = '0;
        bus.wl_feedback_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",  bus.busy_o, 0);
        checkOutput("rst_cs_n",  bus.ctl_cs_n_o, 1);
        checkOutput("rst_cmd",   {bus.ctl_ras_n_o, bus.ctl_cas_n_o, bus.ctl_we_n_o}, 3'b111);
        checkOutput("rst_odt",   bus.ctl_odt_o, 0);
        checkOutput("rst_wl",    bus.ctl_write_level_o, 0);
        checkOutput("rst_taps",  bus.tap_count_o, 0);
        checkOutput("rst_flags", {bus.done_o, bus.error_o, bus.ctl_out_dqs_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Lane 0 locks at tap 5, lane 1 at tap 9
        applyStimulus(~32'h0000_001F, ~32'h0000_01FF, 14'h0044, 1'b0);
        // Feedback stuck at 1: both lanes run out of taps
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h1234, 1'b0);
        // Lane 0 reads 1 at tap 0 first: must not lock there, locks at 3
        applyStimulus(32'hFFFF_FFF9, ~32'h0000_0003, 14'h00FF, 1'b0);
        // start held through the whole sequence: one run only
        applyStimulus(~32'h0000_0007, ~32'h0000_003F, 14'h0200, 1'b1);
        repeat (30) @(negedge clk);
        checkOutput("held_start_single_done", done_cnt, 1);
        checkOutput("held_start_idle", bus.busy_o, 0);

        // Reset while waiting for feedback
        clearMonitor();
        pat[0] = '1;
        pat[1] = '1;
        bus.mr1_value_i = 14'h0044;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        waited = 0;
        while (!bus.ctl_out_dqs_o && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reach_wait_wlo", 32'(waited < BUDGET), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_odt",  bus.ctl_odt_o, 0);
        checkOutput("midrst_wl",   bus.ctl_write_level_o, 0);
        checkOutput("midrst_busy", bus.busy_o, 0);
        checkOutput("midrst_cs_n", bus.ctl_cs_n_o, 1);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("midrst_no_exit_mrs", mrs_cnt, 1);
        checkOutput("midrst_no_pulse", done_cnt + err_cnt, 0);

        // Random feedback patterns
        for (int i = 0; i < 5; i++) begin
            p0 = $urandom;
            p1 = $urandom;
            applyStimulus(p0, p1, ADDR_BITS'($urandom), 1'b0);
        end
        // Random clean thresholds (threshold 0 means stuck at 1)
        for (int i = 0; i < 3; i++) begin
            k  = $urandom_range(0, 31);
            p0 = ~((32'h1 << k) - 32'h1);
            k  = $urandom_range(1, 31);
            p1 = ~((32'h1 << k) - 32'h1);
            applyStimulus(p0, p1, ADDR_BITS'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", check_count, fail_count);
        $finish;
    end
endmodule
